// File: rtl/operand_unpacker.sv
// Operand unpacker for a fused multiply-add front end: classifies three IEEE-754
// operands and buffers the decoded set in a 2-entry FIFO whose head drives all outputs.
module operand_unpacker #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter int PARM_RM   = 3
) (
  input  logic                 Clk_i,
  input  logic                 Rst_n_i,
  input  logic                 Flush_i,
  input  logic                 In_valid_i,
  output logic                 In_ready_o,
  input  logic [PARM_EXP+PARM_MANT:0] A_i,
  input  logic [PARM_EXP+PARM_MANT:0] B_i,
  input  logic [PARM_EXP+PARM_MANT:0] C_i,
  input  logic                 Sub_i,
  input  logic [PARM_RM-1:0]   Rounding_mode_i,
  output logic                 Out_valid_o,
  input  logic                 Out_ready_i,
  output logic                 A_Sign_o,
  output logic [PARM_EXP-1:0]  A_Exp_raw_o,
  output logic [PARM_EXP-1:0]  A_Exp_eff_o,
  output logic [PARM_MANT:0]   A_Mant_o,
  output logic                 A_DeN_o,
  output logic                 A_Inf_o,
  output logic                 A_Zero_o,
  output logic                 A_NaN_o,
  output logic                 A_SNaN_o,
  output logic                 B_Sign_o,
  output logic [PARM_EXP-1:0]  B_Exp_raw_o,
  output logic [PARM_EXP-1:0]  B_Exp_eff_o,
  output logic [PARM_MANT:0]   B_Mant_o,
  output logic                 B_DeN_o,
  output logic                 B_Inf_o,
  output logic                 B_Zero_o,
  output logic                 B_NaN_o,
  output logic                 B_SNaN_o,
  output logic                 C_Sign_o,
  output logic [PARM_EXP-1:0]  C_Exp_raw_o,
  output logic [PARM_EXP-1:0]  C_Exp_eff_o,
  output logic [PARM_MANT:0]   C_Mant_o,
  output logic                 C_DeN_o,
  output logic                 C_Inf_o,
  output logic                 C_Zero_o,
  output logic                 C_NaN_o,
  output logic                 C_SNaN_o,
  output logic                 Sub_Sign_o,
  output logic                 Invalid_pre_o,
  output logic [PARM_RM-1:0]   Rounding_mode_o
);

  localparam int W = PARM_EXP + PARM_MANT + 1;

  typedef struct packed {
    logic                sign;
    logic [PARM_EXP-1:0] expRaw;
    logic [PARM_EXP-1:0] expEff;
    logic [PARM_MANT:0]  mant;
    logic                den;
    logic                inf;
    logic                zero;
    logic                nan;
    logic                snan;
  } opT;

  typedef struct packed {
    opT                 a;
    opT                 b;
    opT                 c;
    logic               subSign;
    logic               invalid;
    logic [PARM_RM-1:0] rm;
  } entryT;

  function automatic opT unpackOp(input logic [W-1:0] x);
    opT o;
    logic [PARM_EXP-1:0]  e;
    logic [PARM_MANT-1:0] f;
    logic expOnes, expZero, fracZero;
    e        = x[W-2 -: PARM_EXP];
    f        = x[PARM_MANT-1:0];
    expOnes  = &e;
    expZero  = ~|e;
    fracZero = ~|f;
    o.sign   = x[W-1];
    o.expRaw = e;
    o.expEff = expZero ? {{(PARM_EXP-1){1'b0}}, 1'b1} : e;
    o.mant   = {~expZero, f};
    o.inf    = expOnes & fracZero;
    o.nan    = expOnes & ~fracZero;
    o.snan   = expOnes & ~fracZero & ~f[PARM_MANT-1];
    o.zero   = expZero & fracZero;
    o.den    = expZero & ~fracZero;
    return o;
  endfunction

  entryT      newEntry;
  entryT      head_q, head_d;
  entryT      tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  // Decode is done before storage so the head register drives outputs directly.
  always_comb begin
    newEntry         = '0;
    newEntry.a       = unpackOp(A_i);
    newEntry.b       = unpackOp(B_i);
    newEntry.c       = unpackOp(C_i);
    newEntry.subSign = A_i[W-1] ^ B_i[W-1] ^ C_i[W-1] ^ Sub_i;
    newEntry.invalid = newEntry.a.nan | newEntry.b.nan | newEntry.c.nan
                     | (newEntry.b.zero & newEntry.c.inf)
                     | (newEntry.c.zero & newEntry.b.inf)
                     | (newEntry.subSign & newEntry.a.inf & (newEntry.b.inf | newEntry.c.inf));
    newEntry.rm      = Rounding_mode_i;
  end

  assign In_ready_o  = (count_q != 2'd2);
  assign Out_valid_o = (count_q != 2'd0);
  assign push        = In_valid_i & In_ready_o;
  assign pop         = Out_valid_o & Out_ready_i;

  // Shift-style FIFO: the head always sits in head_q, the second entry in tail_q.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (Flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = newEntry;
          else                 tail_d = newEntry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: head_d = newEntry;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign A_Sign_o        = head_q.a.sign;
  assign A_Exp_raw_o     = head_q.a.expRaw;
  assign A_Exp_eff_o     = head_q.a.expEff;
  assign A_Mant_o        = head_q.a.mant;
  assign A_DeN_o         = head_q.a.den;
  assign A_Inf_o         = head_q.a.inf;
  assign A_Zero_o        = head_q.a.zero;
  assign A_NaN_o         = head_q.a.nan;
  assign A_SNaN_o        = head_q.a.snan;
  assign B_Sign_o        = head_q.b.sign;
  assign B_Exp_raw_o     = head_q.b.expRaw;
  assign B_Exp_eff_o     = head_q.b.expEff;
  assign B_Mant_o        = head_q.b.mant;
  assign B_DeN_o         = head_q.b.den;
  assign B_Inf_o         = head_q.b.inf;
  assign B_Zero_o        = head_q.b.zero;
  assign B_NaN_o         = head_q.b.nan;
  assign B_SNaN_o        = head_q.b.snan;
  assign C_Sign_o        = head_q.c.sign;
  assign C_Exp_raw_o     = head_q.c.expRaw;
  assign C_Exp_eff_o     = head_q.c.expEff;
  assign C_Mant_o        = head_q.c.mant;
  assign C_DeN_o         = head_q.c.den;
  assign C_Inf_o         = head_q.c.inf;
  assign C_Zero_o        = head_q.c.zero;
  assign C_NaN_o         = head_q.c.nan;
  assign C_SNaN_o        = head_q.c.snan;
  assign Sub_Sign_o      = head_q.subSign;
  assign Invalid_pre_o   = head_q.invalid;
  assign Rounding_mode_o = head_q.rm;

endmodule

// File: tb/tb_operand_unpacker.sv
// Bench for operand_unpacker: directed and random operand sets checked against
// a queue-based reference model that decodes IEEE-754 fields arithmetically.
module tb_operand_unpacker;

  logic        Clk_i, Rst_n_i, Flush_i, In_valid_i, In_ready_o;
  logic [31:0] A_i, B_i, C_i;
  logic        Sub_i;
  logic [2:0]  Rounding_mode_i;
  logic        Out_valid_o, Out_ready_i;
  logic        A_Sign_o, B_Sign_o, C_Sign_o;
  logic [7:0]  A_Exp_raw_o, A_Exp_eff_o, B_Exp_raw_o, B_Exp_eff_o, C_Exp_raw_o, C_Exp_eff_o;
  logic [23:0] A_Mant_o, B_Mant_o, C_Mant_o;
  logic        A_DeN_o, A_Inf_o, A_Zero_o, A_NaN_o, A_SNaN_o;
  logic        B_DeN_o, B_Inf_o, B_Zero_o, B_NaN_o, B_SNaN_o;
  logic        C_DeN_o, C_Inf_o, C_Zero_o, C_NaN_o, C_SNaN_o;
  logic        Sub_Sign_o, Invalid_pre_o;
  logic [2:0]  Rounding_mode_o;

  operand_unpacker dut (
    .Clk_i(Clk_i), .Rst_n_i(Rst_n_i), .Flush_i(Flush_i),
    .In_valid_i(In_valid_i), .In_ready_o(In_ready_o),
    .A_i(A_i), .B_i(B_i), .C_i(C_i), .Sub_i(Sub_i), .Rounding_mode_i(Rounding_mode_i),
    .Out_valid_o(Out_valid_o), .Out_ready_i(Out_ready_i),
    .A_Sign_o(A_Sign_o), .A_Exp_raw_o(A_Exp_raw_o), .A_Exp_eff_o(A_Exp_eff_o), .A_Mant_o(A_Mant_o),
    .A_DeN_o(A_DeN_o), .A_Inf_o(A_Inf_o), .A_Zero_o(A_Zero_o), .A_NaN_o(A_NaN_o), .A_SNaN_o(A_SNaN_o),
    .B_Sign_o(B_Sign_o), .B_Exp_raw_o(B_Exp_raw_o), .B_Exp_eff_o(B_Exp_eff_o), .B_Mant_o(B_Mant_o),
    .B_DeN_o(B_DeN_o), .B_Inf_o(B_Inf_o), .B_Zero_o(B_Zero_o), .B_NaN_o(B_NaN_o), .B_SNaN_o(B_SNaN_o),
    .C_Sign_o(C_Sign_o), .C_Exp_raw_o(C_Exp_raw_o), .C_Exp_eff_o(C_Exp_eff_o), .C_Mant_o(C_Mant_o),
    .C_DeN_o(C_DeN_o), .C_Inf_o(C_Inf_o), .C_Zero_o(C_Zero_o), .C_NaN_o(C_NaN_o), .C_SNaN_o(C_SNaN_o),
    .Sub_Sign_o(Sub_Sign_o), .Invalid_pre_o(Invalid_pre_o), .Rounding_mode_o(Rounding_mode_o)
  );

  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  typedef struct {
    logic [31:0] a, b, c;
    logic        sub;
    logic [2:0]  rm;
  } setT;

  typedef struct {
    bit       sign;
    bit [7:0] expRaw, expEff;
    bit [23:0] mant;
    bit       den, inf, zero, nan, snan;
  } opExpT;

  setT model[$];
  setT curSet;
  int  checks = 0;
  int  miscompares = 0;

  // Reference decode straight from the IEEE-754 field definitions.
  function automatic opExpT refOp(input logic [31:0] x);
    opExpT r;
    int unsigned e, f;
    e = (x >> 23) % 256;
    f = x % 32'h0080_0000;
    r.sign   = x[31];
    r.expRaw = 8'(e);
    r.expEff = (e == 0) ? 8'd1 : 8'(e);
    r.mant   = 24'((e == 0) ? f : f + 32'h0080_0000);
    r.inf    = (e == 255) && (f == 0);
    r.nan    = (e == 255) && (f != 0);
    r.snan   = r.nan && (f < 32'h0040_0000);
    r.zero   = (e == 0) && (f == 0);
    r.den    = (e == 0) && (f != 0);
    return r;
  endfunction

  function automatic logic [31:0] randOp();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 5))
      0: r[30:23] = 8'h00;
      1: begin r[30:23] = 8'h00; r[22:0] = '0; end
      2: begin r[30:23] = 8'hFF; r[22:0] = '0; end
      3: r[30:23] = 8'hFF;
      default: ;
    endcase
    return r;
  endfunction

  function automatic setT randSet();
    setT s;
    s.a = randOp(); s.b = randOp(); s.c = randOp();
    s.sub = 1'($urandom_range(0, 1));
    s.rm  = 3'($urandom_range(0, 7));
    return s;
  endfunction

  function automatic setT mkSet(input logic [31:0] a, b, c, input logic sub, input logic [2:0] rm);
    setT s;
    s.a = a; s.b = b; s.c = c; s.sub = sub; s.rm = rm;
    return s;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      miscompares++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expd);
      $error("[TB] %s differs from reference", tag);
    end
  endtask

  task automatic checkOp(input string n, input logic sg, input logic [7:0] er, input logic [7:0] ee,
                         input logic [23:0] m, input logic [4:0] cls, input opExpT e);
    cmp({n, "_sign"}, 32'(sg), 32'(e.sign));
    cmp({n, "_exp_raw"}, 32'(er), 32'(e.expRaw));
    cmp({n, "_exp_eff"}, 32'(ee), 32'(e.expEff));
    cmp({n, "_mant"}, 32'(m), 32'(e.mant));
    cmp({n, "_class"}, 32'(cls), 32'({e.den, e.inf, e.zero, e.nan, e.snan}));
  endtask

  task automatic checkOutput();
    opExpT ea, eb, ec;
    setT   h;
    bit    sSign, inv;
    cmp("out_valid", 32'(Out_valid_o), 32'(model.size() != 0));
    cmp("in_ready", 32'(In_ready_o), 32'(model.size() != 2));
    if (model.size() != 0) begin
      h  = model[0];
      ea = refOp(h.a); eb = refOp(h.b); ec = refOp(h.c);
      checkOp("a", A_Sign_o, A_Exp_raw_o, A_Exp_eff_o, A_Mant_o,
              {A_DeN_o, A_Inf_o, A_Zero_o, A_NaN_o, A_SNaN_o}, ea);
      checkOp("b", B_Sign_o, B_Exp_raw_o, B_Exp_eff_o, B_Mant_o,
              {B_DeN_o, B_Inf_o, B_Zero_o, B_NaN_o, B_SNaN_o}, eb);
      checkOp("c", C_Sign_o, C_Exp_raw_o, C_Exp_eff_o, C_Mant_o,
              {C_DeN_o, C_Inf_o, C_Zero_o, C_NaN_o, C_SNaN_o}, ec);
      sSign = ea.sign ^ eb.sign ^ ec.sign ^ h.sub;
      inv   = ea.nan || eb.nan || ec.nan || (eb.zero && ec.inf) || (ec.zero && eb.inf)
              || (sSign && ea.inf && (eb.inf || ec.inf));
      cmp("sub_sign", 32'(Sub_Sign_o), 32'(sSign));
      cmp("invalid_pre", 32'(Invalid_pre_o), 32'(inv));
      cmp("rounding_mode", 32'(Rounding_mode_o), 32'(h.rm));
    end
  endtask

  task automatic checkReset();
    logic anyData;
    anyData = |{A_Sign_o, A_Exp_raw_o, A_Exp_eff_o, A_Mant_o, A_DeN_o, A_Inf_o, A_Zero_o, A_NaN_o, A_SNaN_o,
                B_Sign_o, B_Exp_raw_o, B_Exp_eff_o, B_Mant_o, B_DeN_o, B_Inf_o, B_Zero_o, B_NaN_o, B_SNaN_o,
                C_Sign_o, C_Exp_raw_o, C_Exp_eff_o, C_Mant_o, C_DeN_o, C_Inf_o, C_Zero_o, C_NaN_o, C_SNaN_o,
                Sub_Sign_o, Invalid_pre_o, Rounding_mode_o};
    cmp("rst_out_valid", 32'(Out_valid_o), 32'd0);
    cmp("rst_in_ready", 32'(In_ready_o), 32'd1);
    cmp("rst_data_zero", 32'(anyData), 32'd0);
  endtask

  task automatic applyStimulus(input setT s, input logic valid);
    A_i = s.a; B_i = s.b; C_i = s.c; Sub_i = s.sub; Rounding_mode_i = s.rm;
    In_valid_i = valid;
    curSet = s;
  endtask

  // One clock cycle: check the settled outputs, then advance the model on the edge.
  task automatic tick(output bit pushed);
    bit doPush, doPop;
    @(negedge Clk_i);
    checkOutput();
    doPush = In_valid_i && (model.size() < 2);
    doPop  = Out_ready_i && (model.size() > 0);
    @(posedge Clk_i);
    pushed = 1'b0;
    if (Flush_i) begin
      model.delete();
    end else begin
      if (doPop) model.delete(0);
      if (doPush) begin
        model.push_back(curSet);
        pushed = 1'b1;
      end
    end
    #1;
  endtask

  task automatic sendOne(input setT s);
    bit pushed;
    pushed = 1'b0;
    applyStimulus(s, 1'b1);
    for (int i = 0; i < 20 && !pushed; i++) tick(pushed);
    In_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    bit p;
    for (int i = 0; i < n; i++) tick(p);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit   pushed;
    setT  s1, s2, s3;
    Rst_n_i = 1'b0; Flush_i = 1'b0; Out_ready_i = 1'b0;
    applyStimulus(mkSet(32'h0, 32'h0, 32'h0, 1'b0, 3'd0), 1'b0);
    #2;
    checkReset();
    @(posedge Clk_i); @(posedge Clk_i);
    #3 Rst_n_i = 1'b1;

    // Normal operand, denormal C
    Out_ready_i = 1'b1;
    sendOne(mkSet(32'h3F80_0000, 32'h4000_0000, 32'h0000_0001, 1'b0, 3'd2));
    cmp("d37_out_valid", 32'(Out_valid_o), 32'd1);
    cmp("d37_a_mant", 32'(A_Mant_o), 32'h80_0000);
    cmp("d37_a_exp_eff", 32'(A_Exp_eff_o), 32'd127);
    cmp("d37_c_den", 32'(C_DeN_o), 32'd1);
    cmp("d37_c_exp_eff", 32'(C_Exp_eff_o), 32'd1);
    cmp("d37_c_mant", 32'(C_Mant_o), 32'h00_0001);
    cmp("d37_invalid", 32'(Invalid_pre_o), 32'd0);
    idle(2);

    // Zero times infinity, signalling NaN on A
    sendOne(mkSet(32'h7FA0_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 3'd1));
    cmp("d38_b_zero", 32'(B_Zero_o), 32'd1);
    cmp("d38_c_inf", 32'(C_Inf_o), 32'd1);
    cmp("d38_invalid", 32'(Invalid_pre_o), 32'd1);
    cmp("d38_a_nan", 32'(A_NaN_o), 32'd1);
    cmp("d38_a_snan", 32'(A_SNaN_o), 32'd1);
    idle(1);

    // Inf - Inf*1 is invalid, Inf + Inf*1 is not
    sendOne(mkSet(32'h7F80_0000, 32'h7F80_0000, 32'h3F80_0000, 1'b1, 3'd0));
    cmp("d39_sub_sign", 32'(Sub_Sign_o), 32'd1);
    cmp("d39_invalid_sub", 32'(Invalid_pre_o), 32'd1);
    idle(1);
    sendOne(mkSet(32'h7F80_0000, 32'h7F80_0000, 32'h3F80_0000, 1'b0, 3'd0));
    cmp("d39_invalid_add", 32'(Invalid_pre_o), 32'd0);
    idle(2);

    // Backpressure: third set held until the buffer drains
    Out_ready_i = 1'b0;
    s1 = randSet(); s2 = randSet(); s3 = randSet();
    sendOne(s1);
    sendOne(s2);
    applyStimulus(s3, 1'b1);
    cmp("d40_in_ready_full", 32'(In_ready_o), 32'd0);
    tick(pushed);
    tick(pushed);
    Out_ready_i = 1'b1;
    cmp("d40_in_ready_indep", 32'(In_ready_o), 32'd0);
    pushed = 1'b0;
    for (int i = 0; i < 10 && !pushed; i++) tick(pushed);
    In_valid_i = 1'b0;
    idle(4);

    // Steady push and pop at occupancy one
    Out_ready_i = 1'b0;
    sendOne(randSet());
    Out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(randSet(), 1'b1);
      tick(pushed);
      cmp("d41_out_valid", 32'(Out_valid_o), 32'd1);
    end
    In_valid_i = 1'b0;
    idle(2);

    // Flush while full discards the simultaneous push
    Out_ready_i = 1'b0;
    sendOne(randSet());
    sendOne(randSet());
    applyStimulus(randSet(), 1'b1);
    Flush_i = 1'b1;
    tick(pushed);
    Flush_i = 1'b0;
    In_valid_i = 1'b0;
    cmp("d42_flush_valid", 32'(Out_valid_o), 32'd0);
    cmp("d42_flush_ready", 32'(In_ready_o), 32'd1);
    idle(1);

    // Asynchronous reset mid-stream, then a fresh push
    sendOne(randSet());
    sendOne(randSet());
    #2 Rst_n_i = 1'b0;
    #1 checkReset();
    model.delete();
    idle(2);
    #2 Rst_n_i = 1'b1;
    s1 = randSet();
    Out_ready_i = 1'b0;
    sendOne(s1);
    cmp("d42_first_after_rst", 32'(Rounding_mode_o), 32'(s1.rm));
    cmp("d42_first_after_rst_a", 32'(A_Exp_raw_o), 32'(s1.a[30:23]));
    idle(1);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      applyStimulus(randSet(), 1'($urandom_range(0, 3) != 0));
      Out_ready_i = 1'($urandom_range(0, 1));
      Flush_i     = ($urandom_range(0, 24) == 0);
      tick(pushed);
    end
    Flush_i = 1'b0;
    In_valid_i = 1'b0;
    Out_ready_i = 1'b1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
    $finish;
  end

endmodule
